// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  localparam logic [3:0] WSTRB_B0 = 4'b0001;
  localparam logic [3:0] WSTRB_B1 = 4'b0010;
  localparam logic [3:0] WSTRB_B2 = 4'b0100;
  localparam logic [3:0] WSTRB_B3 = 4'b1000;
  localparam logic [3:0] WSTRB_H0 = 4'b0011;
  localparam logic [3:0] WSTRB_H1 = 4'b1100;
  localparam logic [3:0] WSTRB_W  = 4'b1111;

  // Byte flag has priority over half flag when a decoder sets both.
  function automatic lsu_size_e decode_size(input logic low_byte, input logic half_word);
    if (low_byte)
      return SZ_B;
    else if (half_word)
      return SZ_H;
    else
      return SZ_W;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Handshaked data-memory bus between the LSU (master) and data memory (slave).
interface lsu_mem_port_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half/word out of a read word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  lsu_size_e   i_size,
  input  logic        i_zero_ext,
  output logic [31:0] o_data
);

  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign w_lane[gi] = i_rdata[8*gi +: 8];
  end

  assign w_byte = w_lane[i_addr_lo];
  assign w_half = i_addr_lo[1] ? {w_lane[3], w_lane[2]} : {w_lane[1], w_lane[0]};

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_B:    o_data = {{24{~i_zero_ext & w_byte[7]}}, w_byte};
      SZ_H:    o_data = {{16{~i_zero_ext & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store unit: turns decoder flags into one lane-aligned memory
// transaction, stalls the pipeline while it is outstanding, returns extended load data.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read_mem,
  input  logic          i_write_mem,
  input  logic          i_memin_low_byte,
  input  logic          i_memin_half_word,
  input  logic          i_memout_low_byte,
  input  logic          i_memout_half_word,
  input  logic          i_padding_zero,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_store_data,
  lsu_mem_port_if.master mem,
  output logic [DW-1:0] o_load_data,
  output logic          o_load_valid,
  output logic          o_lsu_stall,
  output logic          o_lsu_err
);

  lsu_state_e    r_state, w_state_next;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_wdata;
  lsu_size_e     r_ld_size;
  logic          r_zero_ext;
  logic [31:0]   r_load_data;
  logic          r_err;

  lsu_size_e     w_st_size, w_ld_size, w_size;
  logic          w_req, w_illegal, w_misaligned, w_accept, w_err_next;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata;
  logic [31:0]   w_align_data;
  logic          w_mem_req, w_stall, w_load_valid;

  assign w_st_size    = decode_size(i_memin_low_byte, i_memin_half_word);
  assign w_ld_size    = decode_size(i_memout_low_byte, i_memout_half_word);
  assign w_size       = i_write_mem ? w_st_size : w_ld_size;
  assign w_req        = i_read_mem ^ i_write_mem;
  assign w_illegal    = i_read_mem & i_write_mem;
  assign w_misaligned = w_req & is_misaligned(w_size, i_addr[1:0]);
  assign w_accept     = (r_state == IDLE) & w_req & ~w_misaligned;
  assign w_err_next   = (r_state == IDLE) & (w_illegal | w_misaligned);

  always_comb begin
    w_wstrb = WSTRB_W;
    w_wdata = i_store_data;
    case (w_size)
      SZ_B: begin
        case (i_addr[1:0])
          2'd0:    w_wstrb = WSTRB_B0;
          2'd1:    w_wstrb = WSTRB_B1;
          2'd2:    w_wstrb = WSTRB_B2;
          default: w_wstrb = WSTRB_B3;
        endcase
        w_wdata = {4{i_store_data[7:0]}};
      end
      SZ_H: begin
        w_wstrb = i_addr[1] ? WSTRB_H1 : WSTRB_H0;
        w_wdata = {2{i_store_data[15:0]}};
      end
      default: begin
        w_wstrb = WSTRB_W;
        w_wdata = i_store_data;
      end
    endcase
  end

  // Stall is raised combinationally in the accepting IDLE cycle so the
  // upstream stage freezes before the request is even on the bus.
  always_comb begin
    w_state_next = r_state;
    w_mem_req    = 1'b0;
    w_stall      = 1'b0;
    w_load_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = REQ;
          w_stall      = 1'b1;
        end
      end
      REQ: begin
        w_mem_req = 1'b1;
        w_stall   = 1'b1;
        if (mem.mem_ready)
          w_state_next = DONE;
      end
      DONE: begin
        w_load_valid = ~r_we;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .i_rdata    (mem.mem_rdata),
    .i_addr_lo  (r_addr[1:0]),
    .i_size     (r_ld_size),
    .i_zero_ext (r_zero_ext),
    .o_data     (w_align_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wstrb     <= 4'b0000;
      r_wdata     <= 32'h0;
      r_ld_size   <= SZ_B;
      r_zero_ext  <= 1'b0;
      r_load_data <= 32'h0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_accept) begin
        r_addr     <= i_addr;
        r_we       <= i_write_mem;
        r_wstrb    <= w_wstrb;
        r_wdata    <= w_wdata;
        r_ld_size  <= w_ld_size;
        r_zero_ext <= i_padding_zero;
      end
      if ((r_state == REQ) && mem.mem_ready && !r_we)
        r_load_data <= w_align_data;
    end
  end

  assign mem.mem_req   = w_mem_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_wstrb = r_wstrb;
  assign mem.mem_addr  = {r_addr[AW-1:2], 2'b00};
  assign mem.mem_wdata = r_wdata;
  assign o_load_data   = r_load_data;
  assign o_load_valid  = w_load_valid;
  assign o_lsu_stall   = w_stall;
  assign o_lsu_err     = r_err;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized and directed bench for lsu_mem_port against a transaction-level reference model.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 0, wr = 0, mlb = 0, mhw = 0, olb = 0, ohw = 0, pz = 0;
  logic [31:0] addr = 0, sdata = 0;
  logic [31:0] load_data;
  logic        load_valid, stall, err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_load = 32'h0;

  lsu_mem_port_if #(.AW(32)) bus ();

  lsu_mem_port #(.AW(32), .DW(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_read_mem         (rd),
    .i_write_mem        (wr),
    .i_memin_low_byte   (mlb),
    .i_memin_half_word  (mhw),
    .i_memout_low_byte  (olb),
    .i_memout_half_word (ohw),
    .i_padding_zero     (pz),
    .i_addr             (addr),
    .i_store_data       (sdata),
    .mem                (bus.master),
    .o_load_data        (load_data),
    .o_load_valid       (load_valid),
    .o_lsu_stall        (stall),
    .o_lsu_err          (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Access size: 0 = byte, 1 = half, 2 = word.
  function automatic int size_of(input logic lb, input logic hw);
    return lb ? 0 : (hw ? 1 : 2);
  endfunction

  function automatic logic [3:0] exp_strb(input int sz, input logic [1:0] a);
    if (sz == 0) return 4'(1 << a);
    if (sz == 1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
    if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input int sz, input logic [1:0] a, input logic zx,
                                           input logic [31:0] rdw);
    logic [31:0] v;
    if (sz == 0) begin
      v = (rdw >> (8 * a)) & 32'hFF;
      if (!zx && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 1) begin
      v = (rdw >> (16 * a[1])) & 32'hFFFF;
      if (!zx && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rdw;
    end
    return v;
  endfunction

  // One transaction: request driven in cycle 0, memory holds mem_ready low for
  // t_wait REQ cycles, then completes it.
  task automatic txn(input string tag, input logic t_rd, input logic t_wr,
                     input logic t_mlb, input logic t_mhw, input logic t_olb, input logic t_ohw,
                     input logic t_pz, input logic [31:0] t_addr, input logic [31:0] t_sdata,
                     input logic [31:0] t_rdata, input int t_wait);
    int  st_sz, ld_sz, sz;
    bit  is_req, misal, legal, is_load, exp_err;
    int  n_stall, n_req, n_valid, n_err;
    logic [31:0] exp_ld;
    st_sz   = size_of(t_mlb, t_mhw);
    ld_sz   = size_of(t_olb, t_ohw);
    sz      = t_wr ? st_sz : ld_sz;
    is_req  = t_rd ^ t_wr;
    misal   = (sz == 1 && t_addr[0]) || (sz == 2 && t_addr[1:0] != 2'b00);
    legal   = is_req && !misal;
    is_load = legal && t_rd;
    exp_err = (t_rd && t_wr) || (is_req && misal);
    exp_ld  = exp_load(ld_sz, t_addr[1:0], t_pz, t_rdata);
    n_stall = 0; n_req = 0; n_valid = 0; n_err = 0;

    @(negedge clk);
    rd = t_rd; wr = t_wr; mlb = t_mlb; mhw = t_mhw; olb = t_olb; ohw = t_ohw; pz = t_pz;
    addr = t_addr; sdata = t_sdata;
    bus.mem_ready = 1'b0; bus.mem_rdata = t_rdata;
    for (int c = 0; c < t_wait + 8; c++) begin
      #1;
      if (stall) n_stall++;
      if (err) n_err++;
      if (bus.mem_req) begin
        n_req++;
        check_val({tag, ".addr"}, bus.mem_addr, t_addr & 32'hFFFF_FFFC);
        check_val({tag, ".we"}, 32'(bus.mem_we), 32'(t_wr));
        if (t_wr) begin
          check_val({tag, ".wstrb"}, 32'(bus.mem_wstrb), 32'(exp_strb(st_sz, t_addr[1:0])));
          check_val({tag, ".wdata"}, bus.mem_wdata, exp_wdata(st_sz, t_sdata));
        end
        bus.mem_ready = (n_req > t_wait);
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (load_valid) begin
        n_valid++;
        check_val({tag, ".load_data"}, load_data, exp_ld);
      end
      @(negedge clk);
      rd = 0; wr = 0; mlb = 0; mhw = 0; olb = 0; ohw = 0; pz = 0;
    end
    if (is_load) model_load = exp_ld;
    check_val({tag, ".n_req"}, 32'(n_req), legal ? 32'(t_wait + 1) : 32'd0);
    check_val({tag, ".n_stall"}, 32'(n_stall), legal ? 32'(t_wait + 2) : 32'd0);
    check_val({tag, ".n_valid"}, 32'(n_valid), is_load ? 32'd1 : 32'd0);
    check_val({tag, ".n_err"}, 32'(n_err), exp_err ? 32'd1 : 32'd0);
    check_val({tag, ".hold"}, load_data, model_load);
    $display("txn %s rd=%0b wr=%0b addr=%08h wait=%0d req=%0d stall=%0d valid=%0d err=%0d load_data=%08h",
             tag, t_rd, t_wr, t_addr, t_wait, n_req, n_stall, n_valid, n_err, load_data);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".mem_req"}, 32'(bus.mem_req), 32'd0);
    check_val({tag, ".mem_we"}, 32'(bus.mem_we), 32'd0);
    check_val({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    check_val({tag, ".mem_addr"}, bus.mem_addr, 32'd0);
    check_val({tag, ".mem_wdata"}, bus.mem_wdata, 32'd0);
    check_val({tag, ".load_data"}, load_data, 32'd0);
    check_val({tag, ".load_valid"}, 32'(load_valid), 32'd0);
    check_val({tag, ".stall"}, 32'(stall), 32'd0);
    check_val({tag, ".err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int op, w;
    logic [31:0] ra;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    txn("sw",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    txn("sb",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0);
    txn("sh",   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h102, 32'h00001234, 32'h0, 0);
    txn("sbh",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h101, 32'h5566_7788, 32'h0, 1);
    // mem_ready low for three cycles counting the request cycle -> four stall cycles
    txn("lb",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 32'h0000_8000, 2);
    txn("lbu",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 32'h0000_8000, 2);
    txn("lh",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 32'h8001_0000, 0);
    txn("lhu",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 32'h8001_0000, 0);
    txn("lbh",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 32'h9A12_3456, 0);
    txn("lwmis",1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h102, 32'h0, 32'h1111_2222, 0);
    txn("shmis",1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h101, 32'hCAFE, 32'h0, 0);
    txn("rdwr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      w  = $urandom_range(0, 3);
      ra = $urandom;
      txn($sformatf("rnd%0d", i), (op == 0) || (op >= 2 && op <= 5), (op == 0) || (op >= 6),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          ra, $urandom, $urandom, w);
    end

    // Reset while a load waits in REQ.
    @(negedge clk);
    rd = 1'b1; addr = 32'h200; bus.mem_ready = 1'b0;
    @(negedge clk);
    rd = 1'b0;
    #1 check_val("midrst.pre_req", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    model_load = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    txn("sw2",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
